uart_tx_ser: RTL

- Serialising UART transmitter directly downstream of the byte test generator.
- Accepts a parallel byte on a single-cycle load strobe and shifts it out LSB-first on the tx line in standard asynchronous framing.
- Drives busy back to the generator, which holds its next byte until busy is low.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_ser_if.sv | 14 +
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_tx_ser.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: frame states, parity encodings and the parity helper.
// Used by the transmitter now and by the receiver later.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_tx_ser_if.sv
// Byte-load interface between the byte generator (master) and the UART serialiser (slave).
interface uart_tx_ser_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] din;
  logic                 load;
  logic                 busy;
  logic                 tx;
  logic                 overrun;

  modport master (output din, output load, input busy, input tx, input overrun);
  modport slave  (input din, input load, output busy, output tx, output overrun);

endinterface

// File: rtl/uart_bit_timer.sv
// Serial bit timer: counts CLKS_PER_BIT cycles per bit and flags the last cycle with bit_end.
// clr restarts the count from zero on the next cycle; the count wraps by itself after bit_end.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ser.sv
// UART transmitter: loads a byte on a strobe and shifts it out LSB-first with start, optional parity and stop bits.
// All outputs registered; tx drops one cycle after an accepted load.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_ser_if.slave  bus
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $fatal(1, "uart_tx_ser: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $fatal(1, "uart_tx_ser: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $fatal(1, "uart_tx_ser: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 held_q, held_d;
  logic                 accept;
  logic                 bit_end;
  logic                 timer_clr;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          accept  = 1'b1;
          state_d = ST_START;
          shift_d = bus.din;
          par_d   = parity_bit(bus.din, PARITY);
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          stop_d  = 1'b0;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line value follows the state being entered so tx and busy change on the same edge.
  always_comb begin
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign timer_clr = (state_q == ST_IDLE) || (state_d != state_q);
  assign busy_d    = (state_d != ST_IDLE);

  // A load level held continuously since its acceptance is a request for the next
  // frame, not a new byte, so it does not count as an overrun while the frame runs.
  assign held_d    = bus.load && (held_q || accept);
  assign overrun_d = bus.load && (state_q != ST_IDLE) && !held_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      held_q    <= held_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule
